bcd_scan_display: RTL and testbench

Parametrised sequential binary-to-BCD converter with a built-in multiplexed 7-segment scanner. A binary value is accepted over a valid/ready handshake and converted iteratively with double-dabble, one bit per cycle. The result is latched into a display register that a free-running scanner walks digit by digit, driving one-hot digit selects and decoded segments with optional leading-zero blanking. It sits between the numeric datapath and the board's LED display pins, replacing one-digit-at-a-time combinational BCD lookup.

---
 rtl/bcd_scan_pkg.sv | 29 ++
 rtl/bcd_scan_display_seg7.sv | 12 +
 rtl/bcd_scan_display.sv | 139 +++++++++++++
 tb/tb_bcd_scan_display.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the BCD converter / 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Codes 10-15 never come out of the converter; they decode to blank.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_display_seg7.sv
// Combinational BCD nibble to 7-segment decoder with a blank override.
module seg7_decode
  import bcd_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_LUT[nibble_i];

endmodule

// File: rtl/bcd_scan_display.sv
// Sequential double-dabble binary-to-BCD converter feeding a free-running
// multiplexed 7-segment scanner with optional leading-zero blanking.
module bcd_scan_display
  import bcd_scan_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  num_valid,
  input  logic [WIDTH-1:0]      num,
  output logic                  num_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            segments
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  // DIGITS >= ceil(WIDTH*log10(2)), evaluated in fixed point.
  if (DIGITS * 100000 < WIDTH * 30103) begin : g_digits_chk
    $error("bcd_scan_display: DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 1) begin : g_div_chk
    $error("bcd_scan_display: SCAN_DIV must be >= 1");
  end

  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_e               state_q;
  logic                 rdy_q, busy_q;
  logic [WIDTH-1:0]     shift_q;
  logic [BW-1:0]        scratch_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BW-1:0]        bcd_q;
  logic [BW+WIDTH-1:0]  dd_d;

  assign dd_d = {dabble(scratch_q), shift_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (num_valid) begin
            shift_q   <= num;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(WIDTH);
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          {scratch_q, shift_q} <= dd_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= LOAD;
        end
        LOAD: begin
          // Only place the visible result changes: no partial values on display.
          bcd_q   <= scratch_q;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] sel_q;
  logic [6:0]        seg_q;
  logic [BW-1:0]     upper_d;
  logic              blank_d;
  logic [6:0]        seg_d;

  // Current nibble sits at the bottom; anything left above it is more significant.
  assign upper_d = bcd_q >> {idx_q, 2'b00};
  assign blank_d = (BLANK_LZ != 0) && (idx_q != '0) && (upper_d == '0);

  seg7_decode u_dec (
    .nibble_i (upper_d[3:0]),
    .blank_i  (blank_d),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      sel_q <= '0;
      seg_q <= '0;
    end else begin
      sel_q <= SEL_ONE << idx_q;
      seg_q <= seg_d;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign num_ready = rdy_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;
  assign digit_sel = sel_q;
  assign segments  = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized bench for bcd_scan_display: two configurations checked every
// cycle against a decimal-arithmetic reference model.
module tb_bcd_scan_display;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Configuration A: WIDTH 16, DIGITS 5, SCAN_DIV 4, blanking on
  logic        a_vld, a_rdy, a_busy;
  logic [15:0] a_num;
  logic [19:0] a_bcd;
  logic [4:0]  a_sel;
  logic [6:0]  a_seg;

  // Configuration B: WIDTH 8, DIGITS 3, SCAN_DIV 1, blanking off
  logic        b_vld, b_rdy, b_busy;
  logic [7:0]  b_num;
  logic [11:0] b_bcd;
  logic [2:0]  b_sel;
  logic [6:0]  b_seg;

  bcd_scan_display #(.WIDTH(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .num_valid(a_vld), .num(a_num),
    .num_ready(a_rdy), .busy(a_busy), .bcd(a_bcd),
    .digit_sel(a_sel), .segments(a_seg)
  );

  bcd_scan_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(1), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst_n(rst_n), .num_valid(b_vld), .num(b_num),
    .num_ready(b_rdy), .busy(b_busy), .bcd(b_bcd),
    .digit_sel(b_sel), .segments(b_seg)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int unsigned v, input int idx, input bit bl);
    int unsigned d;
    d = (v / pow10(idx)) % 10;
    if (bl && idx != 0 && v < pow10(idx)) return 7'h00;
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference: a transfer makes the value visible WIDTH+1 edges later;
  // the display shows position floor(edges/SCAN_DIV) mod DIGITS one edge late.
  int          ma_left, ma_cyc;
  int unsigned ma_val, ma_pend;
  logic [4:0]  ea_sel;
  logic [6:0]  ea_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_left <= 0; ma_cyc <= 0; ma_val <= 0; ma_pend <= 0;
      ea_sel <= '0; ea_seg <= '0;
    end else begin
      ea_sel <= 5'(1 << ((ma_cyc / 4) % 5));
      ea_seg <= seg_of(ma_val, (ma_cyc / 4) % 5, 1'b1);
      ma_cyc <= ma_cyc + 1;
      if (ma_left == 1) begin
        ma_val <= ma_pend; ma_left <= 0;
      end else if (ma_left > 1) begin
        ma_left <= ma_left - 1;
      end else if (a_vld) begin
        ma_pend <= a_num; ma_left <= 17;
      end
    end
  end

  int          mb_left, mb_cyc;
  int unsigned mb_val, mb_pend;
  logic [2:0]  eb_sel;
  logic [6:0]  eb_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_left <= 0; mb_cyc <= 0; mb_val <= 0; mb_pend <= 0;
      eb_sel <= '0; eb_seg <= '0;
    end else begin
      eb_sel <= 3'(1 << (mb_cyc % 3));
      eb_seg <= seg_of(mb_val, mb_cyc % 3, 1'b0);
      mb_cyc <= mb_cyc + 1;
      if (mb_left == 1) begin
        mb_val <= mb_pend; mb_left <= 0;
      end else if (mb_left > 1) begin
        mb_left <= mb_left - 1;
      end else if (b_vld) begin
        mb_pend <= b_num; mb_left <= 9;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_eq("a_ready", a_rdy, ma_left == 0);
      check_eq("a_busy",  a_busy, ma_left != 0);
      check_eq("a_bcd",   a_bcd, to_bcd(ma_val));
      check_eq("a_sel",   a_sel, ea_sel);
      check_eq("a_seg",   a_seg, ea_seg);
      check_eq("b_ready", b_rdy, mb_left == 0);
      check_eq("b_busy",  b_busy, mb_left != 0);
      check_eq("b_bcd",   b_bcd, 12'(to_bcd(mb_val)));
      check_eq("b_sel",   b_sel, eb_sel);
      check_eq("b_seg",   b_seg, eb_seg);
    end
  end

  task automatic send_a(input logic [15:0] v);
    bit took;
    int n;
    took = 1'b0; n = 0;
    a_num = v; a_vld = 1'b1;
    while (!took && n < 200) begin
      took = a_rdy;
      @(negedge clk);
      n++;
    end
    a_vld = 1'b0;
    check_eq("a_accept", took, 1'b1);
  endtask

  task automatic send_b(input logic [7:0] v);
    bit took;
    int n;
    took = 1'b0; n = 0;
    b_num = v; b_vld = 1'b1;
    while (!took && n < 200) begin
      took = b_rdy;
      @(negedge clk);
      n++;
    end
    b_vld = 1'b0;
    check_eq("b_accept", took, 1'b1);
  endtask

  initial begin
    a_vld = 1'b0; a_num = '0;
    b_vld = 1'b0; b_num = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_sel", a_sel, 5'b00001);
    check_eq("first_seg", a_seg, 7'h3F);

    send_a(16'd1234);
    repeat (17) @(negedge clk);
    check_eq("bcd_1234", a_bcd, 20'h01234);
    repeat (25) @(negedge clk);

    send_a(16'd0);
    repeat (17) @(negedge clk);
    check_eq("bcd_0", a_bcd, 20'h00000);
    repeat (22) @(negedge clk);

    send_a(16'd65535);
    repeat (17) @(negedge clk);
    check_eq("bcd_65535", a_bcd, 20'h65535);
    repeat (22) @(negedge clk);

    // Valid held high with a moving value: only the value at each accept counts.
    a_vld = 1'b1;
    repeat (80) begin
      a_num = 16'($urandom);
      @(negedge clk);
    end
    a_vld = 1'b0;
    repeat (20) @(negedge clk);

    repeat (20) begin
      send_a(16'($urandom));
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    // Reset in the eighth conversion cycle.
    send_a(16'd50000);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_bcd",   a_bcd, 20'h0);
    check_eq("rst_sel",   a_sel, 5'b0);
    check_eq("rst_seg",   a_seg, 7'h0);
    check_eq("rst_ready", a_rdy, 1'b1);
    check_eq("rst_busy",  a_busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_bcd_hold", a_bcd, 20'h0);

    send_a(16'd42);
    repeat (17) @(negedge clk);
    check_eq("bcd_42", a_bcd, 20'h00042);
    repeat (6) @(negedge clk);
    send_a(16'd6677);
    repeat (30) @(negedge clk);

    send_b(8'd255);
    repeat (9) @(negedge clk);
    check_eq("bcd_255", b_bcd, 12'h255);
    repeat (5) @(negedge clk);
    send_b(8'd0);
    repeat (14) @(negedge clk);
    repeat (15) begin
      send_b(8'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
